fwrisc_mem_target: RTL and testbench
====================================

FWRISC_MEM_TARGET -- requirements
Module: fwrisc_mem_target

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, giving the number of 32-bit words in the array (power of two).
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, giving idle cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port iaddr  input  32  instruction fetch byte address.
REQ-006 The block SHALL have port ivalid  input  1  fetch request, held by the requester until iready.
REQ-007 The block SHALL have port iready  output  1  one-cycle fetch completion pulse.
REQ-008 The block SHALL have port idata  output  32  fetched word, valid while iready=1.
REQ-009 The block SHALL have port daddr  input  32  data byte address.
REQ-010 The block SHALL have port dwdata  input  32  write data.
REQ-011 The block SHALL have port dstrb  input  4  byte-write enables; bit n covers bits 8n+7:8n.
REQ-012 The block SHALL have port dwrite  input  1  1=write, 0=read.
REQ-013 The block SHALL have port dvalid  input  1  data request, held by the requester until dready.
REQ-014 The block SHALL have port dready  output  1  one-cycle data completion pulse.
REQ-015 The block SHALL have port drdata  output  32  read word, valid while dready=1 on a read.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 In IDLE with dvalid=1 the block SHALL accept the data request, latching daddr, dwdata, dstrb and dwrite, with port select = D.
REQ-018 In IDLE with ivalid=1 and dvalid=0 the block SHALL accept the fetch, latching iaddr, with port select = I; data has fixed priority when both are valid.
REQ-019 On acceptance the block SHALL load the wait counter with WAIT_STATES and go to WAIT, or go directly to RESP when WAIT_STATES=0.
REQ-020 In WAIT the block SHALL decrement the counter each cycle and go to RESP in the cycle after the counter reaches 0.
REQ-021 Latency: for acceptance at edge N, ready SHALL be high during cycle N+1+WAIT_STATES.
REQ-022 In RESP the block SHALL assert exactly the selected port's ready for one cycle, then return to IDLE.
REQ-023 An accepted request SHALL NOT be pre-empted, and the other port's ready SHALL stay 0 throughout.
REQ-024 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] and upper bits SHALL be ignored, so out-of-range addresses alias by wrap-around.
REQ-025 A read SHALL present the full 32-bit word on idata or drdata in the RESP cycle; byte and half-word selection belongs to the requester.
REQ-026 A write SHALL update only the strobed bytes at the RESP edge; dstrb=0 SHALL leave memory unchanged and still complete with dready.
REQ-027 idata and drdata SHALL be registered and hold their last value outside RESP; a write response SHALL NOT change drdata.
REQ-028 A read in the cycle after a write to the same word SHALL return the newly written bytes.
REQ-029 A request dropped before ready SHALL still complete: a write SHALL commit and ready SHALL still pulse.
REQ-030 Because ready drops in the cycle after RESP, valid still high in that IDLE cycle SHALL be taken as a new request.

Reset
REQ-031 While reset=1 the block SHALL set state=IDLE, counter=0, iready=0, dready=0, idata=0 and drdata=0.
REQ-032 Reset mid-operation SHALL abort the pending access: no write commits and no ready pulse follows.
REQ-033 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-034 Package fwrisc_mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP) and the port-select enum (PORT_I/PORT_D).
REQ-035 Sub-module fwrisc_sram SHALL implement the single-port DEPTH_WORDS x 32 array with byte-write enables and registered read.
REQ-036 All other arbitration, counting and handshake logic SHALL be in fwrisc_mem_target.

Verification
REQ-037 With WAIT_STATES=1, a fetch at iaddr=0x10 of a word preloaded as 0x00500093 SHALL give iready with idata=0x00500093 exactly 2 cycles after acceptance, and dready=0 throughout.
REQ-038 Writing dwdata=0xAABBCCDD with dstrb=4'b0101 to 0x20 over a zero word, then reading 0x20, SHALL return drdata=0x00BB00DD.
REQ-039 Raising ivalid and dvalid in the same cycle SHALL serve data first (dready), then the fetch, with iready exactly 2 cycles after dready (WAIT_STATES=0: accept, RESP).
REQ-040 With DEPTH_WORDS=4096, a write of 0x12345678 to 0x4000 followed by a read of 0x0000 SHALL return 0x12345678 (alias).
REQ-041 Asserting reset during WAIT of a write to 0x30 SHALL give no dready, leave the old word at 0x30, and return iready/dready/idata/drdata to 0.
REQ-042 With WAIT_STATES=0, back-to-back fetches SHALL complete every 2 cycles with a single-cycle iready each.

Source files
------------

// File: rtl/fwrisc_mem_pkg.sv
// Shared types for the fwrisc dual-port (fetch/data) memory target.
// Holds the handshake FSM states and the port-select encoding.
package fwrisc_mem_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_sel_e;

endpackage

// File: rtl/fwrisc_sram.sv
// Single-port DEPTH_WORDS x 32 word array with byte-write enables and a
// registered read port; reads and writes never share a cycle in this design.
module fwrisc_sram #(
    parameter int DEPTH_WORDS = 4096,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IDX_W-1:0] addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [3:0]       wstrb,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array gets no reset branch; contents must survive reset, and a
    // reset term here would also stop the tools from mapping it onto RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/fwrisc_mem_target.sv
// Memory target serving an instruction-fetch port and a data port with fixed
// data priority, a programmable wait-state count and one-cycle ready pulses.
module fwrisc_mem_target
    import fwrisc_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] iaddr,
    input  logic        ivalid,
    output logic        iready,
    output logic [31:0] idata,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [3:0]  dstrb,
    input  logic        dwrite,
    input  logic        dvalid,
    output logic        dready,
    output logic [31:0] drdata
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    port_sel_e        sel_q, sel_nxt;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [31:0]      wdata_q, wdata_nxt;
    logic [3:0]       strb_q, strb_nxt;
    logic             write_q, write_nxt;
    logic [31:0]      idata_q, drdata_q;
    logic [31:0]      sram_rdata;
    logic             sram_rd_en, sram_wr_en;
    logic             resp_i, resp_d, resp_d_rd;

    // Only the word-index bits of each address take part in the lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iaddr[31:IDX_W+2], iaddr[1:0],
                                daddr[31:IDX_W+2], daddr[1:0]};

    // NOTE: every signal this block drives gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel_q;
        idx_nxt   = idx_q;
        wdata_nxt = wdata_q;
        strb_nxt  = strb_q;
        write_nxt = write_q;
        case (state)
            IDLE: begin
                if (dvalid) begin
                    sel_nxt   = PORT_D;
                    idx_nxt   = daddr[IDX_W+1:2];
                    wdata_nxt = dwdata;
                    strb_nxt  = dstrb;
                    write_nxt = dwrite;
                end else if (ivalid) begin
                    sel_nxt   = PORT_I;
                    idx_nxt   = iaddr[IDX_W+1:2];
                    write_nxt = 1'b0;
                end
                if (dvalid || ivalid) begin
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_INIT == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // The count reaches zero on the same edge that enters RESP.
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_i    = (state == RESP) && (sel_q == PORT_I);
    assign resp_d    = (state == RESP) && (sel_q == PORT_D);
    assign resp_d_rd = resp_d && !write_q;

    // Reads land in the SRAM output register on the edge entering RESP;
    // writes commit on the edge leaving RESP, so the two never collide.
    assign sram_rd_en = (state_nxt == RESP) && (state != RESP) && !write_nxt;
    assign sram_wr_en = resp_d && write_q;

    assign iready = resp_i;
    assign dready = resp_d;
    assign idata  = resp_i    ? sram_rdata : idata_q;
    assign drdata = resp_d_rd ? sram_rdata : drdata_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sel_q    <= PORT_I;
            idx_q    <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            idata_q  <= '0;
            drdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sel_q   <= sel_nxt;
            idx_q   <= idx_nxt;
            wdata_q <= wdata_nxt;
            strb_q  <= strb_nxt;
            write_q <= write_nxt;
            if (resp_i) begin
                idata_q <= sram_rdata;
            end
            if (resp_d_rd) begin
                drdata_q <= sram_rdata;
            end
        end
    end

    fwrisc_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clock(clock),
        .reset(reset),
        .addr (idx_nxt),
        .rd_en(sram_rd_en),
        .wr_en(sram_wr_en),
        .wstrb(strb_q),
        .wdata(wdata_q),
        .rdata(sram_rdata)
    );

endmodule

// File: tb/tb_fwrisc_mem_target.sv
// Directed bench for fwrisc_mem_target: instance 0 runs WAIT_STATES=0,
// instance 1 runs WAIT_STATES=1; inputs driven and outputs sampled on negedge.
module tb_fwrisc_mem_target;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] iaddr  [2];
    logic        ivalid [2];
    logic        iready [2];
    logic [31:0] idata  [2];
    logic [31:0] daddr  [2];
    logic [31:0] dwdata [2];
    logic [3:0]  dstrb  [2];
    logic        dwrite [2];
    logic        dvalid [2];
    logic        dready [2];
    logic [31:0] drdata [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    fwrisc_mem_target #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) u_dut_w0 (
        .clock(clock), .reset(reset),
        .iaddr(iaddr[0]), .ivalid(ivalid[0]), .iready(iready[0]), .idata(idata[0]),
        .daddr(daddr[0]), .dwdata(dwdata[0]), .dstrb(dstrb[0]), .dwrite(dwrite[0]),
        .dvalid(dvalid[0]), .dready(dready[0]), .drdata(drdata[0])
    );

    fwrisc_mem_target #(.DEPTH_WORDS(4096), .WAIT_STATES(1)) u_dut_w1 (
        .clock(clock), .reset(reset),
        .iaddr(iaddr[1]), .ivalid(ivalid[1]), .iready(iready[1]), .idata(idata[1]),
        .daddr(daddr[1]), .dwdata(dwdata[1]), .dstrb(dstrb[1]), .dwrite(dwrite[1]),
        .dvalid(dvalid[1]), .dready(dready[1]), .drdata(drdata[1])
    );

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            iaddr[d]  = '0;
            ivalid[d] = 1'b0;
            daddr[d]  = '0;
            dwdata[d] = '0;
            dstrb[d]  = '0;
            dwrite[d] = 1'b0;
            dvalid[d] = 1'b0;
        end
    endtask

    // One request; lat counts cycles from the accepting edge to the ready cycle.
    task automatic access(input int d, input bit is_data, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output int lat, output bit other_seen);
        bit got = 1'b0;
        lat = 0;
        other_seen = 1'b0;
        rdata = '0;
        @(negedge clock);
        if (is_data) begin
            daddr[d] = addr; dwdata[d] = wd; dstrb[d] = strb;
            dwrite[d] = wr;  dvalid[d] = 1'b1;
        end else begin
            iaddr[d] = addr; ivalid[d] = 1'b1;
        end
        while (!got && lat < 40) begin
            @(negedge clock);
            lat++;
            if (is_data ? iready[d] : dready[d]) other_seen = 1'b1;
            if (is_data ? dready[d] : iready[d]) begin
                got = 1'b1;
                rdata = is_data ? drdata[d] : idata[d];
            end
        end
        dvalid[d] = 1'b0;
        ivalid[d] = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL access_timeout: dut %0d addr %h no ready within %0d cycles", d, addr, lat);
        end
    endtask

    task automatic write_word(input int d, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] s);
        logic [31:0] r;
        int l;
        bit o;
        access(d, 1'b1, 1'b1, a, wd, s, r, l, o);
    endtask

    task automatic read_word(input int d, input logic [31:0] a, output logic [31:0] r);
        int l;
        bit o;
        access(d, 1'b1, 1'b0, a, '0, '0, r, l, o);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (iready[d] !== 1'b0 || dready[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ready: dut %0d iready %b dready %b expected 0 0", d, iready[d], dready[d]);
            end
            vectors++;
            if (idata[d] !== 32'h0 || drdata[d] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_data: dut %0d idata %h drdata %h expected 0 0", d, idata[d], drdata[d]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_fetch();
        logic [31:0] r;
        int lat;
        bit other;
        write_word(1, 32'h10, 32'h0050_0093, 4'hF);
        access(1, 1'b0, 1'b0, 32'h10, '0, '0, r, lat, other);
        vectors++;
        if (r !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL fetch_data: got %h expected %h", r, 32'h0050_0093);
        end
        vectors++;
        if (lat != 2) begin
            miscompares++;
            $display("FAIL fetch_latency: got %0d cycles expected 2", lat);
        end
        vectors++;
        if (other !== 1'b0) begin
            miscompares++;
            $display("FAIL fetch_no_dready: dready seen %b expected 0", other);
        end
        @(negedge clock);
        vectors++;
        if (iready[1] !== 1'b0 || idata[1] !== 32'h0050_0093) begin
            miscompares++;
            $display("FAIL fetch_pulse_hold: iready %b idata %h expected 0 00500093", iready[1], idata[1]);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] r;
        int lat;
        bit other;
        write_word(1, 32'h20, 32'h0, 4'hF);
        write_word(1, 32'h20, 32'hAABB_CCDD, 4'b0101);
        read_word(1, 32'h20, r);
        vectors++;
        if (r !== 32'h00BB_00DD) begin
            miscompares++;
            $display("FAIL strobe_merge: got %h expected %h", r, 32'h00BB_00DD);
        end
        // Zero-strobe write completes, and its response leaves drdata alone.
        access(1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, r, lat, other);
        vectors++;
        if (lat != 2 || r !== 32'h00BB_00DD) begin
            miscompares++;
            $display("FAIL strobe_zero_resp: lat %0d drdata %h expected 2 00bb00dd", lat, r);
        end
        read_word(1, 32'h20, r);
        vectors++;
        if (r !== 32'h00BB_00DD) begin
            miscompares++;
            $display("FAIL strobe_zero_mem: got %h expected %h", r, 32'h00BB_00DD);
        end
    endtask

    task automatic test_alias();
        logic [31:0] r;
        write_word(1, 32'h4000, 32'h1234_5678, 4'hF);
        read_word(1, 32'h0000, r);
        vectors++;
        if (r !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL alias_wrap: got %h expected %h", r, 32'h1234_5678);
        end
        read_word(1, 32'h0003, r);
        vectors++;
        if (r !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL alias_low_bits: got %h expected %h", r, 32'h1234_5678);
        end
    endtask

    task automatic test_dropped();
        logic [31:0] r;
        bit seen = 1'b0;
        @(negedge clock);
        daddr[1] = 32'h50; dwdata[1] = 32'hCAFE_F00D; dstrb[1] = 4'hF;
        dwrite[1] = 1'b1; dvalid[1] = 1'b1;
        @(negedge clock);
        dvalid[1] = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (dready[1]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL dropped_ready: dready seen %b expected 1", seen);
        end
        read_word(1, 32'h50, r);
        vectors++;
        if (r !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL dropped_commit: got %h expected %h", r, 32'hCAFE_F00D);
        end
    endtask

    task automatic test_priority();
        int dcyc = 0;
        int icyc = 0;
        logic [31:0] dval = '0;
        logic [31:0] ival = '0;
        write_word(0, 32'h40, 32'h0BAD_BEEF, 4'hF);
        write_word(0, 32'h44, 32'h0000_0013, 4'hF);
        @(negedge clock);
        daddr[0] = 32'h40; dwrite[0] = 1'b0; dvalid[0] = 1'b1;
        iaddr[0] = 32'h44; ivalid[0] = 1'b1;
        for (int c = 1; c <= 20 && (dcyc == 0 || icyc == 0); c++) begin
            @(negedge clock);
            if (dready[0]) begin dcyc = c; dval = drdata[0]; dvalid[0] = 1'b0; end
            if (iready[0]) begin icyc = c; ival = idata[0];  ivalid[0] = 1'b0; end
        end
        dvalid[0] = 1'b0;
        ivalid[0] = 1'b0;
        vectors++;
        if (dcyc != 1 || icyc != 3) begin
            miscompares++;
            $display("FAIL priority_order: dready cycle %0d iready cycle %0d expected 1 3", dcyc, icyc);
        end
        vectors++;
        if (dval !== 32'h0BAD_BEEF || ival !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL priority_data: drdata %h idata %h expected 0badbeef 00000013", dval, ival);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        int cyc [4] = '{0, 0, 0, 0};
        logic [31:0] got [4] = '{0, 0, 0, 0};
        int n = 0;
        for (int k = 0; k < 4; k++) write_word(0, 32'h100 + 32'(4*k), exp_word[k], 4'hF);
        @(negedge clock);
        iaddr[0] = 32'h100; ivalid[0] = 1'b1;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(negedge clock);
            if (iready[0]) begin
                cyc[n] = c;
                got[n] = idata[0];
                n++;
                if (n == 4) ivalid[0] = 1'b0;
                else iaddr[0] = 32'h100 + 32'(4*n);
            end
        end
        ivalid[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (got[k] !== exp_word[k] || cyc[k] != 1 + 2*k) begin
                miscompares++;
                $display("FAIL b2b_fetch%0d: idata %h at cycle %0d expected %h at cycle %0d",
                         k, got[k], cyc[k], exp_word[k], 1 + 2*k);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] r;
        bit seen = 1'b0;
        write_word(1, 32'h30, 32'h1111_1111, 4'hF);
        read_word(1, 32'h30, r);
        @(negedge clock);
        daddr[1] = 32'h30; dwdata[1] = 32'h2222_2222; dstrb[1] = 4'hF;
        dwrite[1] = 1'b1; dvalid[1] = 1'b1;
        @(negedge clock);
        reset = 1'b1;
        dvalid[1] = 1'b0;
        @(negedge clock);
        vectors++;
        if (iready[1] !== 1'b0 || dready[1] !== 1'b0 || idata[1] !== 32'h0 || drdata[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: iready %b dready %b idata %h drdata %h expected all 0",
                     iready[1], dready[1], idata[1], drdata[1]);
        end
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (dready[1]) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_no_ready: dready seen %b expected 0", seen);
        end
        read_word(1, 32'h30, r);
        vectors++;
        if (r !== 32'h1111_1111) begin
            miscompares++;
            $display("FAIL abort_no_commit: got %h expected %h", r, 32'h1111_1111);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_strobe();
        test_alias();
        test_dropped();
        test_priority();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
